present_wb_regbank: RTL and testbench
=====================================

PRESENT_WB_REGBANK -- requirements
Module: present_wb_regbank

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0000, byte address of word 0.
REQ-002 SHALL have parameter KEY_WORDS, default 3, number of 32-bit RW key words.
REQ-003 SHALL have parameter DATA_WORDS, default 2, number of 32-bit RW plaintext words.
REQ-004 SHALL have parameter RES_WORDS, default 2, number of 32-bit RO result words.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, busy-cycle limit; used only under PRESENT_WB_TIMEOUT_EN.
REQ-006 SHALL have one clock and an asynchronous active-low reset: wb_clk_i in 1 (clock), wb_rst_i in 1 (asynchronous active-low reset).
REQ-007 SHALL have Wishbone slave ports: wbs_stb_i in 1; wbs_cyc_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_adr_i in 32; wbs_dat_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-008 SHALL have core ports: key_o out 32*KEY_WORDS; data_o out 32*DATA_WORDS; start_o out 1 (one-cycle pulse); done_i in 1; result_i in 32*RES_WORDS.
REQ-009 SHALL have irq_o out 1, level interrupt.

Function
REQ-010 Word index = (wbs_adr_i-BASE_ADDRESS)>>2; map: key [0,KEY_WORDS), data next, result next, CTRL at N-2, STATUS at N-1, N = KEY_WORDS+DATA_WORDS+RES_WORDS+2.
REQ-011 Access is valid when wbs_cyc_i&wbs_stb_i, address within [BASE_ADDRESS, BASE_ADDRESS+4N), and adr[1:0]==0.
REQ-012 wbs_ack_o SHALL assert exactly one cycle after a valid access, for one cycle; no ack while ack is high (no back-to-back); out-of-window or misaligned: never acked.
REQ-013 wbs_dat_o SHALL be registered and presented with ack; write cycles and reserved bits read 0.
REQ-014 Key/data/CTRL writes SHALL honour wbs_sel_i per byte; result and STATUS words are read-only except STATUS W1C bits.
REQ-015 CTRL: bit0 START (write-1 action, reads 0), bit1 IRQ_EN (RW).
REQ-016 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C, sticky), bit3 TIMEOUT (W1C, sticky).
REQ-017 FSM states IDLE, BUSY, DONE; IDLE/DONE --START--> BUSY with start_o pulsed that cycle+1 and DONE cleared; BUSY --done_i--> DONE, result_i captured into result words same edge; DONE --DONE W1C--> IDLE.
REQ-018 START written in BUSY SHALL be ignored and set ERR.
REQ-019 Key or data writes in BUSY SHALL be discarded and set ERR; reads always permitted.
REQ-020 done_i outside BUSY SHALL be ignored; result words unchanged.
REQ-021 done_i and DONE W1C in the same cycle: set wins, DONE remains 1.
REQ-022 done_i and START write in the same BUSY cycle: transition to DONE, START ignored, ERR set.
REQ-023 irq_o = DONE & IRQ_EN, combinational from registered bits.

Reset
REQ-024 On wb_rst_i low, asynchronously: FSM IDLE, all storage/result words 0, CTRL/STATUS 0, wbs_ack_o 0, wbs_dat_o 0, start_o 0, irq_o 0.
REQ-025 Reset mid-transaction SHALL drop any pending ack; reset in BUSY returns to IDLE with no start_o.

Configuration
REQ-026 With PRESENT_WB_TIMEOUT_EN defined, a counter SHALL run in BUSY; on reaching TIMEOUT_CYCLES without done_i, go to DONE, set TIMEOUT, leave result words unchanged; counter clears on entry to BUSY.
REQ-027 Without PRESENT_WB_TIMEOUT_EN, no counter SHALL exist, BUSY waits indefinitely, TIMEOUT reads 0.

Structure
REQ-028 Package present_wb_pkg SHALL hold FSM state typedef, CTRL/STATUS bit-index constants, and word-offset constants.
REQ-029 FSM plus timeout counter SHALL be sub-module present_wb_ctrl_fsm; decode/storage stay in the top.

Verification
REQ-030 Write KEY words 0x1111_1111/0x2222_2222/0x0000_3333, sel=4'hF -> key_o={0x0000_3333,0x2222_2222,0x1111_1111}, readback equal, ack 1 cycle after stb.
REQ-031 Write 0xAABB_CCDD sel=4'b0101 to DATA0 (previously 0) -> reads 0x00BB_00DD.
REQ-032 CTRL=0x3, done_i after 10 cycles with result_i=0xDEAD_BEEF_0123_4567 -> one start_o pulse, STATUS=0x2, result reads 0x0123_4567/0xDEAD_BEEF, irq_o=1; write STATUS=0x2 -> irq_o=0, IDLE.
REQ-033 START again and key write in BUSY -> no second start_o, key unchanged, STATUS=0x5.
REQ-034 Access BASE_ADDRESS+4N and BASE_ADDRESS+2 -> no ack for 8 cycles; reset asserted mid-access -> ack never asserts.
REQ-035 With PRESENT_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done_i -> DONE after 16 busy cycles, STATUS=0xA.

Source files
------------

// File: rtl/present_wb_pkg.sv
// Shared types and constants for the PRESENT Wishbone register bank:
// FSM state encoding, CTRL/STATUS bit positions and word-offset helpers.
package present_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_ERR_BIT     = 2;
    localparam int STAT_TIMEOUT_BIT = 3;

    localparam int KEY_WORD0 = 0;

    // Word map: key words, then data words, then result words, then CTRL, STATUS.
    function automatic int data_word0(input int key_words);
        return KEY_WORD0 + key_words;
    endfunction

    function automatic int res_word0(input int key_words, input int data_words);
        return data_word0(key_words) + data_words;
    endfunction

    function automatic int ctrl_word(input int key_words, input int data_words, input int res_words);
        return res_word0(key_words, data_words) + res_words;
    endfunction

    function automatic int status_word(input int key_words, input int data_words, input int res_words);
        return ctrl_word(key_words, data_words, res_words) + 1;
    endfunction

    function automatic int num_words(input int key_words, input int data_words, input int res_words);
        return status_word(key_words, data_words, res_words) + 1;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/present_wb_ctrl_fsm.sv
// Start/done sequencing FSM for the PRESENT register bank. The optional busy
// timeout counter is built only when PRESENT_WB_TIMEOUT_EN is defined.
module present_wb_ctrl_fsm
    import present_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start_req,
    input  logic   done_clr,
    input  logic   done_in,
    output state_t state,
    output logic   start_pulse,
    output logic   capture,
    output logic   timeout_hit
);

    // done_in only matters while busy; it also beats a simultaneous START.
    assign capture = (state == ST_BUSY) && done_in;

`ifdef PRESENT_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt;

    assign timeout_hit = (state == ST_BUSY) && !done_in &&
                         (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            start_pulse <= 1'b0;
`ifdef PRESENT_WB_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
        end else begin
            start_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_req) begin
                        state       <= ST_BUSY;
                        start_pulse <= 1'b1;
`ifdef PRESENT_WB_TIMEOUT_EN
                        busy_cnt    <= '0;
`endif
                    end else if (state == ST_DONE && done_clr) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (capture || timeout_hit) begin
                        state <= ST_DONE;
                    end
`ifdef PRESENT_WB_TIMEOUT_EN
                    else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/present_wb_regbank.sv
// Wishbone register bank feeding key/plaintext to a PRESENT core and collecting
// its result. Busy timeout is available when PRESENT_WB_TIMEOUT_EN is defined.
module present_wb_regbank
    import present_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter int          KEY_WORDS      = 3,
    parameter int          DATA_WORDS     = 2,
    parameter int          RES_WORDS      = 2,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [32*KEY_WORDS-1:0] key_o,
    output logic [32*DATA_WORDS-1:0] data_o,
    output logic                    start_o,
    input  logic                    done_i,
    input  logic [32*RES_WORDS-1:0] result_i,
    output logic                    irq_o
);

    localparam int N      = num_words(KEY_WORDS, DATA_WORDS, RES_WORDS);
    localparam int DATA0  = data_word0(KEY_WORDS);
    localparam int RES0   = res_word0(KEY_WORDS, DATA_WORDS);
    localparam int CTRL_W = ctrl_word(KEY_WORDS, DATA_WORDS, RES_WORDS);
    localparam int STAT_W = status_word(KEY_WORDS, DATA_WORDS, RES_WORDS);

    logic [31:0] offset;
    logic [29:0] word;
    logic        access, wr, rd;

    logic [31:0] key_q  [KEY_WORDS];
    logic [31:0] data_q [DATA_WORDS];
    logic [31:0] res_q  [RES_WORDS];
    logic        irq_en_q, err_q, timeout_q;
    logic [31:0] rdata;

    state_t state;
    logic   busy, done, capture, timeout_hit;
    logic   start_req, done_clr, store_wr, err_set, stat_wr, ctrl_wr;

    // Addresses below the base wrap to large offsets and fall outside the window.
    assign offset = wbs_adr_i - BASE_ADDRESS;
    assign word   = offset[31:2];
    assign access = wbs_cyc_i && wbs_stb_i && !wbs_ack_o &&
                    (offset < 32'(4 * N)) && (offset[1:0] == 2'b00);
    assign wr     = access && wbs_we_i;
    assign rd     = access && !wbs_we_i;

    assign busy      = (state == ST_BUSY);
    assign done      = (state == ST_DONE);
    assign ctrl_wr   = wr && (word == 30'(CTRL_W));
    assign stat_wr   = wr && (word == 30'(STAT_W));
    assign store_wr  = wr && (word < 30'(RES0));
    assign start_req = ctrl_wr && wbs_sel_i[0] && wbs_dat_i[CTRL_START_BIT];
    assign done_clr  = stat_wr && wbs_dat_i[STAT_DONE_BIT];
    assign err_set   = busy && (start_req || store_wr);

    present_wb_ctrl_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_i),
        .start_req  (start_req),
        .done_clr   (done_clr),
        .done_in    (done_i),
        .state      (state),
        .start_pulse(start_o),
        .capture    (capture),
        .timeout_hit(timeout_hit)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < KEY_WORDS; i++)  key_q[i]  <= '0;
            for (int i = 0; i < DATA_WORDS; i++) data_q[i] <= '0;
            for (int i = 0; i < RES_WORDS; i++)  res_q[i]  <= '0;
            irq_en_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (store_wr && !busy) begin
                for (int i = 0; i < KEY_WORDS; i++)
                    if (word == 30'(i))
                        key_q[i] <= merge_bytes(key_q[i], wbs_dat_i, wbs_sel_i);
                for (int i = 0; i < DATA_WORDS; i++)
                    if (word == 30'(DATA0 + i))
                        data_q[i] <= merge_bytes(data_q[i], wbs_dat_i, wbs_sel_i);
            end
            if (ctrl_wr && wbs_sel_i[0]) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN_BIT];
            if (capture) begin
                for (int i = 0; i < RES_WORDS; i++) res_q[i] <= result_i[32*i +: 32];
            end
            // Sticky flags: a new event in the same cycle as the clear wins.
            err_q     <= err_set || (err_q && !(stat_wr && wbs_dat_i[STAT_ERR_BIT]));
            timeout_q <= timeout_hit || (timeout_q && !(stat_wr && wbs_dat_i[STAT_TIMEOUT_BIT]));
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < KEY_WORDS; i++)
            if (word == 30'(i)) rdata = key_q[i];
        for (int i = 0; i < DATA_WORDS; i++)
            if (word == 30'(DATA0 + i)) rdata = data_q[i];
        for (int i = 0; i < RES_WORDS; i++)
            if (word == 30'(RES0 + i)) rdata = res_q[i];
        if (word == 30'(CTRL_W)) rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        if (word == 30'(STAT_W)) begin
            rdata[STAT_BUSY_BIT]    = busy;
            rdata[STAT_DONE_BIT]    = done;
            rdata[STAT_ERR_BIT]     = err_q;
            rdata[STAT_TIMEOUT_BIT] = timeout_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= rd ? rdata : '0;
        end
    end

    always_comb begin
        key_o  = '0;
        data_o = '0;
        for (int i = 0; i < KEY_WORDS; i++)  key_o[32*i +: 32]  = key_q[i];
        for (int i = 0; i < DATA_WORDS; i++) data_o[32*i +: 32] = data_q[i];
    end

    assign irq_o = done && irq_en_q;

endmodule

// File: tb/tb_present_wb_regbank.sv
// Randomized scoreboard bench for present_wb_regbank against a transaction-level
// model of the register map, start/done sequencing and optional busy timeout.
module tb_present_wb_regbank;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int KW = 3, DW = 2, RW = 2, TO = 16;
    localparam int N = KW + DW + RW + 2;
    localparam int DATA0 = KW, RES0 = KW + DW, CTRL = N - 2, STAT = N - 1;
`ifdef PRESENT_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk, rst_n;
    logic             stb, cyc, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat_i;
    logic             ack;
    logic [31:0]      dat_o;
    logic [32*KW-1:0] key_o;
    logic [32*DW-1:0] data_o;
    logic             start_o, done_i, irq_o;
    logic [32*RW-1:0] result_i;

    present_wb_regbank #(
        .BASE_ADDRESS(BASE), .KEY_WORDS(KW), .DATA_WORDS(DW),
        .RES_WORDS(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .key_o(key_o), .data_o(data_o), .start_o(start_o),
        .done_i(done_i), .result_i(result_i), .irq_o(irq_o)
    );

    // ---------------- clock / reset ----------------
    int cyc_n = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int tests = 0, fails = 0;
    int act_starts = 0, exp_starts = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: ack=1 with no pending access, required 0 (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("rdata", dat_o, e);
            end
        end
        if (start_o === 1'b1) act_starts++;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_key [KW];
    logic [31:0] m_data[DW];
    logic [31:0] m_res [RW];
    bit m_irq_en, m_err, m_to;
    int m_state;      // 0 idle, 1 busy, 2 done
    int m_busy_edge;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = o;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < KW; i++) m_key[i] = '0;
        for (int i = 0; i < DW; i++) m_data[i] = '0;
        for (int i = 0; i < RW; i++) m_res[i] = '0;
        m_irq_en = 0; m_err = 0; m_to = 0; m_state = 0; m_busy_edge = 0;
    endtask

    // Bring the model to the state seen just before posedge number p.
    task automatic settle(input int p);
        if (TO_EN && m_state == 1 && (p - m_busy_edge) > TO) begin
            m_state = 2;
            m_to = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_read(input int w);
        logic [31:0] v;
        v = '0;
        if (w < DATA0)       v = m_key[w];
        else if (w < RES0)   v = m_data[w - DATA0];
        else if (w < CTRL)   v = m_res[w - RES0];
        else if (w == CTRL)  v = {30'd0, m_irq_en, 1'b0};
        else                 v = {28'd0, m_to, m_err, m_state == 2, m_state == 1};
        return v;
    endfunction

    task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s, input int p);
        if (w < RES0) begin
            if (m_state == 1) m_err = 1'b1;
            else if (w < DATA0) m_key[w] = bmerge(m_key[w], d, s);
            else m_data[w - DATA0] = bmerge(m_data[w - DATA0], d, s);
        end else if (w == CTRL) begin
            if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (m_state == 1) m_err = 1'b1;
                    else begin
                        m_state = 1;
                        m_busy_edge = p;
                        exp_starts++;
                    end
                end
            end
        end else if (w == STAT) begin
            if (d[1] && m_state == 2) m_state = 0;
            if (d[2]) m_err = 1'b0;
            if (d[3]) m_to = 1'b0;
        end
    endtask

    task automatic post_check();
        logic [32*KW-1:0] ke;
        logic [32*DW-1:0] de;
        settle(cyc_n + 1);
        for (int i = 0; i < KW; i++) ke[32*i +: 32] = m_key[i];
        for (int i = 0; i < DW; i++) de[32*i +: 32] = m_data[i];
        check("key_o", key_o, ke);
        check("data_o", data_o, de);
        check("irq_o", irq_o, (m_state == 2) && m_irq_en);
        check("start_count", act_starts, exp_starts);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wb_access(input logic [31:0] a, input bit w_en, input logic [31:0] d,
                             input logic [3:0] s, input bit with_done, input logic [63:0] r);
        int p, w, seen;
        logic [31:0] off;
        bit valid, pre_busy;
        @(negedge clk);
        cyc = 1; stb = 1; we = w_en; adr = a; dat_i = d; sel = s;
        if (with_done) begin
            done_i = 1'b1;
            result_i = r;
        end
        p = cyc_n + 1;
        off = a - BASE;
        valid = (off < 32'(4 * N)) && (off[1:0] == 2'b00);
        w = int'(off >> 2);
        settle(p);
        pre_busy = (m_state == 1);
        if (valid) begin
            exp_q.push_back(w_en ? 32'h0 : model_read(w));
            if (w_en) model_write(w, d, s, p);
        end
        if (with_done && pre_busy) begin
            m_state = 2;
            for (int i = 0; i < RW; i++) m_res[i] = r[32*i +: 32];
        end
        if (valid) begin
            @(negedge clk);
            done_i = 1'b0;
            check("ack_latency", ack, 1'b1);
            cyc = 0; stb = 0; we = 0;
            @(negedge clk);
            check("ack_width", ack, 1'b0);
        end else begin
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                done_i = 1'b0;
                if (ack === 1'b1) seen++;
            end
            check("no_ack_bad_addr", seen, 0);
            cyc = 0; stb = 0; we = 0;
            @(negedge clk);
        end
        post_check();
    endtask

    task automatic wb_write(input int w, input logic [31:0] d, input logic [3:0] s);
        wb_access(BASE + 32'(4 * w), 1'b1, d, s, 1'b0, 64'h0);
    endtask

    task automatic wb_read(input int w);
        wb_access(BASE + 32'(4 * w), 1'b0, 32'h0, 4'hF, 1'b0, 64'h0);
    endtask

    task automatic pulse_done(input logic [63:0] r);
        int p;
        @(negedge clk);
        done_i = 1'b1;
        result_i = r;
        p = cyc_n + 1;
        settle(p);
        if (m_state == 1) begin
            m_state = 2;
            for (int i = 0; i < RW; i++) m_res[i] = r[32*i +: 32];
        end
        @(negedge clk);
        done_i = 1'b0;
        post_check();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int kind, seen_rst;
        logic [31:0] a;
        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        done_i = 0; result_i = '0;
        model_reset();
        idle(3);
        check("reset_ack", ack, 1'b0);
        check("reset_dat_o", dat_o, 32'h0);
        check("reset_start_o", start_o, 1'b0);
        post_check();
        rst_n = 1;

        wb_read(STAT);
        // Key words with full byte enables, then read back.
        wb_write(0, 32'h1111_1111, 4'hF);
        wb_write(1, 32'h2222_2222, 4'hF);
        wb_write(2, 32'h0000_3333, 4'hF);
        check("key_o_direct", key_o, {32'h0000_3333, 32'h2222_2222, 32'h1111_1111});
        for (int i = 0; i < KW; i++) wb_read(i);
        // Partial byte write into a cleared data word.
        wb_write(DATA0, 32'hAABB_CCDD, 4'b0101);
        wb_read(DATA0);

        // Start with IRQ enabled, finish after ~10 cycles.
        wb_write(CTRL, 32'h3, 4'hF);
        idle(6);
        pulse_done(64'hDEAD_BEEF_0123_4567);
        wb_read(STAT);
        wb_read(RES0);
        wb_read(RES0 + 1);
        wb_write(STAT, 32'h2, 4'hF);
        wb_read(STAT);

        // Errors while busy: repeated START and key write.
        wb_write(CTRL, 32'h1, 4'hF);
        wb_write(CTRL, 32'h1, 4'hF);
        wb_write(0, 32'hFFFF_FFFF, 4'hF);
        wb_read(STAT);
        wb_read(0);
        // done_i together with DONE/ERR W1C while busy.
        wb_access(BASE + 32'(4 * STAT), 1'b1, 32'h6, 4'hF, 1'b1, 64'h1234_5678_9ABC_DEF0);
        wb_read(STAT);
        wb_read(RES0);
        wb_write(STAT, 32'hE, 4'hF);
        // done_i together with START while busy.
        wb_write(CTRL, 32'h1, 4'hF);
        wb_access(BASE + 32'(4 * CTRL), 1'b1, 32'h1, 4'hF, 1'b1, 64'h0BAD_F00D_CAFE_0001);
        wb_read(STAT);
        wb_write(STAT, 32'hE, 4'hF);
        // done_i outside busy is ignored.
        pulse_done(64'hFFFF_0000_FFFF_0000);
        wb_read(RES0);

        // Busy-limit boundary: reads land on busy edges 16 and 19.
        wb_write(CTRL, 32'h3, 4'hF);
        idle(13);
        wb_read(STAT);
        wb_read(STAT);
        pulse_done(64'h5555_AAAA_0F0F_F0F0);
        wb_read(STAT);
        wb_write(STAT, 32'hE, 4'hF);

        // Out-of-window, below-base and misaligned accesses.
        wb_access(BASE + 32'(4 * N), 1'b0, 32'h0, 4'hF, 1'b0, 64'h0);
        wb_access(BASE + 32'h2, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 64'h0);
        wb_access(BASE - 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, 64'h0);

        for (int t = 0; t < 90; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                pulse_done({$urandom(), $urandom()});
            end else begin
                a = BASE + 32'(4 * $urandom_range(0, N - 1));
                if (kind == 1)
                    a = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * N) + 32'(4 * $urandom_range(0, 3))
                                                    : a + 32'($urandom_range(1, 3));
                wb_access(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 7) == 0, {$urandom(), $urandom()});
            end
        end

        // Reset in the middle of a START write while busy.
        wb_write(STAT, 32'hE, 4'hF);
        wb_write(CTRL, 32'h1, 4'hF);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'(4 * CTRL); dat_i = 32'h3; sel = 4'hF;
        #2 rst_n = 0;
        seen_rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack === 1'b1) seen_rst++;
        end
        cyc = 0; stb = 0; we = 0;
        model_reset();
        check("ack_in_reset", seen_rst, 0);
        check("dat_o_in_reset", dat_o, 32'h0);
        @(negedge clk);
        rst_n = 1;
        idle(3);
        post_check();
        wb_read(STAT);
        wb_read(0);

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
